// File: rtl/hq_norm_selector.sv
// hq_norm_selector: finds the codebook index q whose 4x2 Hq matrix has the largest sum |Hq(i,j)|^2.
// Define HQ_SEL_METRIC_OUT_EN to drive the per-matrix metric_* outputs (tied to 0 otherwise).
module hq_norm_selector #(
  parameter int unsigned N         = 16,
  parameter int unsigned ACC_WIDTH = 36
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 hq_valid_i,
  input  logic signed [N-1:0]  hq_r_i,
  input  logic signed [N-1:0]  hq_i_i,
  input  logic                 hq_matrix_done_i,
  input  logic                 hq_all_done_i,
  output logic                 busy_o,
  output logic                 sel_valid_o,
  output logic [3:0]           best_q_o,
  output logic [ACC_WIDTH-1:0] best_metric_o,
  output logic                 frame_err_o,
  output logic                 metric_valid_o,
  output logic [3:0]           metric_q_o,
  output logic [ACC_WIDTH-1:0] metric_o
);

  localparam int unsigned MagW = 2 * N + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           elem_cnt_q, elem_cnt_d;
  logic [4:0]           q_cnt_q, q_cnt_d;
  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;
  logic [3:0]           s1_idx_q, s1_idx_d;
  logic [MagW-1:0]      s1_mag_q, s1_mag_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 s2_last_q, s2_last_d;
  logic [3:0]           s2_idx_q, s2_idx_d;
  logic [3:0]           best_q_q, best_q_d;
  logic [ACC_WIDTH-1:0] best_metric_q, best_metric_d;
  logic                 frame_err_q, frame_err_d;
  logic                 sel_valid_q, sel_valid_d;

  logic signed [2*N-1:0] r_ext, i_ext, prod_r, prod_i;
  logic [ACC_WIDTH-1:0]  mag_ext;
  logic                  accept, wrap, last_wrap, clear;

  assign r_ext   = $signed({{N{hq_r_i[N-1]}}, hq_r_i});
  assign i_ext   = $signed({{N{hq_i_i[N-1]}}, hq_i_i});
  assign prod_r  = r_ext * r_ext;
  assign prod_i  = i_ext * i_ext;
  assign mag_ext = {{(ACC_WIDTH - MagW){1'b0}}, s1_mag_q};

  always_comb begin
    state_d       = state_q;
    elem_cnt_d    = elem_cnt_q;
    q_cnt_d       = q_cnt_q;
    acc_d         = acc_q;
    best_q_d      = best_q_q;
    best_metric_d = best_metric_q;
    frame_err_d   = frame_err_q;
    sel_valid_d   = 1'b0;
    clear         = 1'b0;

    accept    = (state_q == StCollect) && hq_valid_i;
    wrap      = accept && (elem_cnt_q == 3'd7);
    last_wrap = wrap && (q_cnt_q == 5'd15);

    // Stage 1: squared magnitude, tagged with framing position taken from our own counters
    s1_vld_d   = accept;
    s1_first_d = (elem_cnt_q == 3'd0);
    s1_last_d  = (elem_cnt_q == 3'd7);
    s1_idx_d   = q_cnt_q[3:0];
    s1_mag_d   = {1'b0, prod_r} + {1'b0, prod_i};

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCollect;
          clear   = 1'b1;
        end
      end
      StCollect: begin
        if (accept) begin
          elem_cnt_d = elem_cnt_q + 3'd1;
          if (hq_matrix_done_i != (elem_cnt_q == 3'd7)) frame_err_d = 1'b1;
          if (wrap) q_cnt_d = q_cnt_q + 5'd1;
          if (last_wrap) state_d = StFlush;
        end
        // The matrix completing in this cycle already counts towards the 16
        if (hq_all_done_i && !last_wrap) frame_err_d = 1'b1;
      end
      StFlush: begin
        if (hq_valid_i) frame_err_d = 1'b1;
        if (!s1_vld_q) begin
          state_d     = StDone;
          sel_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (hq_valid_i) frame_err_d = 1'b1;
        if (!start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Stage 2: accumulate; stage 3: compare on the matrix's final sum
    s2_last_d = s1_vld_q && s1_last_q;
    s2_idx_d  = s1_idx_q;
    if (s1_vld_q) acc_d = s1_first_q ? mag_ext : acc_q + mag_ext;
    if (s2_last_q && ((s2_idx_q == 4'd0) || (acc_q > best_metric_q))) begin
      best_q_d      = s2_idx_q;
      best_metric_d = acc_q;
    end

    if (clear) begin
      elem_cnt_d    = '0;
      q_cnt_d       = '0;
      acc_d         = '0;
      best_q_d      = '0;
      best_metric_d = '0;
      frame_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      elem_cnt_q    <= '0;
      q_cnt_q       <= '0;
      s1_vld_q      <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_idx_q      <= '0;
      s1_mag_q      <= '0;
      acc_q         <= '0;
      s2_last_q     <= 1'b0;
      s2_idx_q      <= '0;
      best_q_q      <= '0;
      best_metric_q <= '0;
      frame_err_q   <= 1'b0;
      sel_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      elem_cnt_q    <= elem_cnt_d;
      q_cnt_q       <= q_cnt_d;
      s1_vld_q      <= s1_vld_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s1_idx_q      <= s1_idx_d;
      s1_mag_q      <= s1_mag_d;
      acc_q         <= acc_d;
      s2_last_q     <= s2_last_d;
      s2_idx_q      <= s2_idx_d;
      best_q_q      <= best_q_d;
      best_metric_q <= best_metric_d;
      frame_err_q   <= frame_err_d;
      sel_valid_q   <= sel_valid_d;
    end
  end

  assign busy_o        = (state_q == StCollect) || (state_q == StFlush);
  assign sel_valid_o   = sel_valid_q;
  assign best_q_o      = best_q_q;
  assign best_metric_o = best_metric_q;
  assign frame_err_o   = frame_err_q;

`ifdef HQ_SEL_METRIC_OUT_EN
  logic                 met_valid_q;
  logic [3:0]           met_idx_q;
  logic [ACC_WIDTH-1:0] met_val_q;

  // Captures the completed sum in parallel with the accumulator update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      met_valid_q <= 1'b0;
      met_idx_q   <= '0;
      met_val_q   <= '0;
    end else begin
      met_valid_q <= s2_last_d;
      if (s2_last_d) begin
        met_idx_q <= s1_idx_q;
        met_val_q <= acc_d;
      end
    end
  end

  assign metric_valid_o = met_valid_q;
  assign metric_q_o     = met_idx_q;
  assign metric_o       = met_val_q;
`else
  assign metric_valid_o = 1'b0;
  assign metric_q_o     = '0;
  assign metric_o       = '0;
`endif

endmodule

// File: doc/hq_norm_selector.md
# hq_norm_selector

Consumes the Hq element stream produced by the codebook matrix multiplier. It accepts 16 candidate 4x2 Hq matrices of 8 complex elements each and computes the Frobenius-norm metric sum |Hq(i,j)|^2 for every candidate. It then reports the codebook index q with the largest metric. It sits directly downstream of the multiplier and feeds precoder selection.

## Interface
- `Q`, 8, fractional bits of input samples (informational; metric kept at full precision, no rescaling)
- `N`, 16, signed width of each real/imag input component
- `ACC_WIDTH`, 36, unsigned metric width; must be >= 2*N+4
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  level; rising use in IDLE begins a selection run
- `hq_valid`  in  1  one Hq element present this cycle; no backpressure
- `hq_r`, `hq_i`  in  N  signed element, real/imag
- `hq_matrix_done`  in  1  coincident with the 8th element of a matrix
- `hq_all_done`  in  1  producer end-of-run level
- `busy`  out  1  high in COLLECT/FLUSH
- `sel_valid`  out  1  one-cycle pulse, result ready
- `best_q`  out  4  winning codebook index
- `best_metric`  out  ACC_WIDTH  metric of `best_q`
- `frame_err`  out  1  sticky framing error for current run
- `metric_valid`  out  1  per-matrix metric pulse (see Configuration)
- `metric_q`  out  4  index of reported metric
- `metric`  out  ACC_WIDTH  per-matrix metric

## Operation
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE: `start`=1 leads to COLLECT. The transition clears elem_cnt (3b), q_cnt (5b), acc, best_metric, best_q, and frame_err. `hq_valid` is ignored in IDLE.
- COLLECT, stage 1: each `hq_valid` registers mag = hq_r*hq_r + hq_i*hq_i.
  - Products are signed 2N; the sum is unsigned 2N+1, zero-extended to ACC_WIDTH.
- COLLECT, stage 2: acc <= acc + mag, or acc <= mag on the first element of a matrix.
- Each accepted element increments elem_cnt.
- When elem_cnt wraps 7->0, the matrix is complete:
  - Compare: update best if metric > best_metric strictly, or if q_cnt==0. Ties keep the lower q.
  - q_cnt increments.
- After the 16th matrix's last element is accepted: COLLECT moves to FLUSH, which waits for the pipeline to drain, then goes to DONE.
- DONE: `sel_valid` pulses once. `best_q` and `best_metric` hold until the next start. Return to IDLE requires `start`=0.
- Framing errors set `frame_err`:
  - `hq_matrix_done`=1 with an element whose elem_cnt != 7;
  - elem_cnt wraps 7->0 without `hq_matrix_done`;
  - `hq_all_done`=1 while in COLLECT before 16 matrices are counted.
- Framing errors never alter counting; the block trusts its own counters.
- `hq_valid` in FLUSH or DONE is ignored and sets `frame_err`.

## Timing
- Reset values: all outputs 0; state IDLE; counters, acc, and best registers 0.
- Element accepted at cycle t: mag registered at the t+1 edge; acc updated at the t+2 edge.
- Last element of a matrix at t:
  - `metric_valid` is high during cycle t+2, with `metric`=final acc.
  - Best registers are updated at the t+3 edge.
- Last element of matrix 15 at t: state is DONE and `sel_valid`=1 during cycle t+3, with final `best_q`/`best_metric`. Latency is 3 cycles.
- `busy` is high from the cycle after start acceptance through the last FLUSH cycle.
- `hq_valid` may be asserted every cycle, including across matrix boundaries. A new matrix's first element may coincide with the previous matrix's compare.
- `start` held high in DONE does not restart; `start`=1 in COLLECT is ignored.
- Reset mid-run: immediate return to IDLE with all outputs 0; the partial run is discarded.
- Arithmetic never overflows: worst case 8*2*2^30 = 2^34 < 2^36.

## Configuration
- `HQ_SEL_METRIC_OUT_EN` defined: `metric_valid`/`metric_q`/`metric` are driven as described in Timing, one pulse per matrix (16 per run).
- Not defined: those three ports are tied to 0, and the per-matrix output register is omitted. Selection behaviour is identical.

## Test plan
- 16 matrices, all elements (128,0), except q=5 with all (256,0), 1 element every 5 cycles -> `best_q`=5, `best_metric`=524288, `sel_valid` one pulse, `frame_err`=0.
- All 16 matrices identical at (100,-100) -> `best_q`=0, `best_metric`=160000.
- Every element (-32768,-32768), `hq_valid` every cycle -> `best_metric`=17179869184, `best_q`=0. With the macro, 16 `metric_valid` pulses with `metric_q` 0..15.
- `hq_matrix_done` asserted on the 5th element of q=2 -> `frame_err`=1 sticky, selection still completes after 128 elements.
- `rst`=0 after 7 matrices, then a fresh run with q=12 largest -> all outputs 0 during reset; second run gives `best_q`=12, `frame_err`=0.
- `start` held high through DONE -> exactly one `sel_valid` pulse; no restart until `start` is low for at least 1 cycle.
